// File: rtl/lif_scheduler.sv
`timescale 1ns/1ps
// lif_scheduler
// Shares one leaky-integrate-and-fire update datapath across N_NEURONS
// virtual neurons. A start request in IDLE launches a timestep sweep that
// updates one neuron per cycle. The resulting spike vector is then held on
// a valid/ready output until the consumer accepts it.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   cur_wr_en/addr/data  write port for the per-neuron input-current registers
//   clear                zero all membrane potentials (IDLE only)
//   start                request one timestep sweep (IDLE only)
//   busy                 high while a sweep runs or its result is pending
//   out_valid/out_ready  handshake for spike_vec
//   spike_vec            bit i = neuron i fired in the last sweep
//   step_count           number of accepted sweeps, wraps modulo 256
//   rd_sel/rd_state      combinational readout of one membrane register
module lif_scheduler #(
    parameter int N_NEURONS  = 4,
    parameter int WIDTH      = 8,
    parameter int THRESHOLD  = 200,
    parameter int LEAK_SHIFT = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cur_wr_en,
    input  logic [$clog2(N_NEURONS)-1:0] cur_wr_addr,
    input  logic [WIDTH-1:0]             cur_wr_data,
    input  logic                         clear,
    input  logic                         start,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_NEURONS-1:0]         spike_vec,
    output logic [7:0]                   step_count,
    input  logic [$clog2(N_NEURONS)-1:0] rd_sel,
    output logic [WIDTH-1:0]             rd_state
);

    localparam int IDX_W = $clog2(N_NEURONS);
    localparam logic [WIDTH-1:0] THR = WIDTH'(THRESHOLD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]     cur_q [N_NEURONS];
    logic [WIDTH-1:0]     cur_d [N_NEURONS];
    logic [WIDTH-1:0]     mem_q [N_NEURONS];
    logic [WIDTH-1:0]     mem_d [N_NEURONS];
    logic [N_NEURONS-1:0] spike_vec_q, spike_vec_d;
    logic [7:0]           step_count_q, step_count_d;

    logic                 last_idx;
    logic                 fire;
    logic [WIDTH-1:0]     mem_sel;
    logic [WIDTH-1:0]     cur_sel;
    logic [WIDTH-1:0]     mem_next;

    // Unsigned add with one guard bit; clamp to all-ones on carry out.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    endfunction

    assign last_idx = (idx_q == IDX_W'(N_NEURONS - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            spike_vec_q  <= '0;
            step_count_q <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                cur_q[i] <= '0;
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            spike_vec_q  <= spike_vec_d;
            step_count_q <= step_count_d;
            for (int i = 0; i < N_NEURONS; i++) begin
                cur_q[i] <= cur_d[i];
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)     state_d = S_RUN;
            S_RUN:   if (last_idx)  state_d = S_HOLD;
            S_HOLD:  if (out_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_HOLD);
    end

    // Shared neuron update; a firing neuron resets and drops this step's current.
    always_comb begin
        mem_sel  = mem_q[idx_q];
        cur_sel  = cur_q[idx_q];
        fire     = (mem_sel >= THR);
        mem_next = fire ? '0 : sat_add(mem_sel >> LEAK_SHIFT, cur_sel);
    end

    // Register-file and counter updates
    always_comb begin
        cur_d        = cur_q;
        mem_d        = mem_q;
        idx_d        = idx_q;
        spike_vec_d  = spike_vec_q;
        step_count_d = step_count_q;

        // The update in RUN reads cur_q, so a same-cycle write lands for the next sweep.
        if (cur_wr_en) cur_d[cur_wr_addr] = cur_wr_data;

        case (state_q)
            S_IDLE: begin
                // clear and start together: the sweep starts from zeroed membranes.
                if (clear) begin
                    for (int i = 0; i < N_NEURONS; i++) mem_d[i] = '0;
                end
                if (start) idx_d = '0;
            end
            S_RUN: begin
                mem_d[idx_q]       = mem_next;
                spike_vec_d[idx_q] = fire;
                idx_d              = idx_q + IDX_W'(1);
            end
            S_HOLD: begin
                if (out_ready) step_count_d = step_count_q + 8'd1;
            end
            default: ;
        endcase
    end

    assign spike_vec  = spike_vec_q;
    assign step_count = step_count_q;
    assign rd_state   = mem_q[rd_sel];

endmodule

// File: tb/tb_lif_scheduler.sv
`timescale 1ns/1ps
module tb_lif_scheduler;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IW  = 2;
    localparam int THR = 200;
    localparam int LS  = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cur_wr_en = 1'b0;
    logic [IW-1:0] cur_wr_addr = '0;
    logic [W-1:0]  cur_wr_data = '0;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  spike_vec;
    logic [7:0]    step_count;
    logic [IW-1:0] rd_sel = '0;
    logic [W-1:0]  rd_state;

    always #5 clk = ~clk;

    lif_scheduler #(
        .N_NEURONS (N),
        .WIDTH     (W),
        .THRESHOLD (THR),
        .LEAK_SHIFT(LS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cur_wr_en  (cur_wr_en),
        .cur_wr_addr(cur_wr_addr),
        .cur_wr_data(cur_wr_data),
        .clear      (clear),
        .start      (start),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .spike_vec  (spike_vec),
        .step_count (step_count),
        .rd_sel     (rd_sel),
        .rd_state   (rd_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] m_mem [N];
    logic [W-1:0] m_cur [N];
    logic [N-1:0] q_spk [$];

    typedef struct {
        bit         rst;
        bit         wr;
        logic [7:0] cur;
        logic [7:0] exp_mem;
        bit         exp_spk;
        logic [7:0] exp_step;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mem[i] = '0;
            m_cur[i] = '0;
        end
        q_spk.delete();
    endtask

    // Reference update for one full sweep; the expected spike vector is queued.
    task automatic model_push();
        logic [N-1:0] s;
        int sum;
        for (int i = 0; i < N; i++) begin
            if (int'(m_mem[i]) >= THR) begin
                m_mem[i] = '0;
                s[i] = 1'b1;
            end else begin
                sum = int'(m_mem[i] >> LS) + int'(m_cur[i]);
                m_mem[i] = (sum > 255) ? 8'hFF : sum[7:0];
                s[i] = 1'b0;
            end
        end
        q_spk.push_back(s);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic wr_cur(input int idx, input logic [W-1:0] v);
        cur_wr_en   = 1'b1;
        cur_wr_addr = IW'(idx);
        cur_wr_data = v;
        tick();
        cur_wr_en   = 1'b0;
        m_cur[idx]  = v;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts edges from the one that samples start until out_valid is seen.
    task automatic wait_valid(output int n);
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic accept();
        logic [N-1:0] e;
        if (q_spk.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = q_spk.pop_front();
            chk("spike_vec", spike_vec, e);
        end
        out_ready = 1'b1;
        tick();
        chk("out_valid_after_accept", out_valid, 0);
        chk("busy_after_accept", busy, 0);
    endtask

    task automatic check_mem_all();
        for (int i = 0; i < N; i++) begin
            rd_sel = IW'(i);
            #1;
            chk($sformatf("mem[%0d]", i), rd_state, m_mem[i]);
        end
    endtask

    task automatic run_sweep();
        int n;
        model_push();
        pulse_start();
        wait_valid(n);
        chk("latency", n, N + 1);
        accept();
        check_mem_all();
    endtask

    task automatic mem_of(input int idx, input logic [W-1:0] exp, input string name);
        rd_sel = IW'(idx);
        #1;
        chk(name, rd_state, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit saw_valid;

        tbl[0]  = '{1, 1, 100, 100, 0, 1};
        tbl[1]  = '{0, 0, 0,   150, 0, 2};
        tbl[2]  = '{0, 0, 0,   175, 0, 3};
        tbl[3]  = '{0, 0, 0,   187, 0, 4};
        tbl[4]  = '{0, 0, 0,   193, 0, 5};
        tbl[5]  = '{0, 0, 0,   196, 0, 6};
        tbl[6]  = '{0, 0, 0,   198, 0, 7};
        tbl[7]  = '{0, 0, 0,   199, 0, 8};
        tbl[8]  = '{0, 0, 0,   199, 0, 9};
        tbl[9]  = '{1, 1, 120, 120, 0, 1};
        tbl[10] = '{0, 0, 0,   180, 0, 2};
        tbl[11] = '{0, 0, 0,   210, 0, 3};
        tbl[12] = '{0, 0, 0,   0,   1, 4};
        tbl[13] = '{0, 0, 0,   120, 0, 5};

        model_reset();

        // Reset state
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_spike_vec", spike_vec, 0);
        chk("rst_step_count", step_count, 0);
        check_mem_all();
        rst_n = 1'b1;
        tick();

        // Convergence and spike/reset sequences on neuron 0
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rst) do_reset();
            if (tbl[i].wr) wr_cur(0, tbl[i].cur);
            run_sweep();
            mem_of(0, tbl[i].exp_mem, $sformatf("tbl%0d_mem0", i));
            chk($sformatf("tbl%0d_spk0", i), spike_vec[0], tbl[i].exp_spk);
            chk($sformatf("tbl%0d_step", i), step_count, tbl[i].exp_step);
        end

        // Saturation on neuron 1
        do_reset();
        wr_cur(1, 8'd150);
        run_sweep();
        mem_of(1, 8'd150, "sat_mem1_s1");
        wr_cur(1, 8'd255);
        run_sweep();
        mem_of(1, 8'd255, "sat_mem1_s2");
        run_sweep();
        chk("sat_spike_s3", spike_vec, 4'b0010);
        mem_of(1, 8'd0, "sat_mem1_s3");

        // Backpressure on the output handshake
        do_reset();
        wr_cur(3, 8'd250);
        run_sweep();
        out_ready = 1'b0;
        model_push();
        pulse_start();
        wait_valid(n);
        chk("bp_latency", n, N + 1);
        for (int k = 0; k < 5; k++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_busy", busy, 1);
            chk("bp_spike_vec", spike_vec, 4'b1000);
            chk("bp_step_count", step_count, 1);
        end
        accept();
        chk("bp_step_after", step_count, 2);
        check_mem_all();
        run_sweep();
        chk("bp_next_step", step_count, 3);

        // Current write colliding with its neuron's update, clear ignored in RUN
        do_reset();
        wr_cur(2, 8'd10);
        model_push();
        pulse_start();
        tick();
        tick();
        cur_wr_en   = 1'b1;
        cur_wr_addr = 2'd2;
        cur_wr_data = 8'd50;
        tick();
        cur_wr_en   = 1'b0;
        m_cur[2]    = 8'd50;
        clear       = 1'b1;
        tick();
        clear       = 1'b0;
        wait_valid(n);
        accept();
        mem_of(2, 8'd10, "col_mem2_old_cur");
        check_mem_all();
        run_sweep();
        mem_of(2, 8'd55, "col_mem2_new_cur");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < N; i++) m_mem[i] = '0;
        check_mem_all();
        run_sweep();
        mem_of(2, 8'd50, "clr_mem2_rebuild");
        clear = 1'b1;
        for (int i = 0; i < N; i++) m_mem[i] = '0;
        model_push();
        pulse_start();
        clear = 1'b0;
        wait_valid(n);
        chk("clr_start_latency", n, N + 1);
        accept();
        mem_of(2, 8'd50, "clr_start_mem2");

        // Asynchronous reset in the middle of a sweep
        for (int i = 0; i < N; i++) wr_cur(i, 8'd100);
        run_sweep();
        model_push();
        pulse_start();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_step_count", step_count, 0);
        model_reset();
        check_mem_all();
        tick();
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid === 1'b1) saw_valid = 1'b1;
        end
        chk("mid_rst_no_valid", saw_valid, 0);
        run_sweep();
        chk("post_rst_spike_vec", spike_vec, 0);
        chk("post_rst_step", step_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
